// File: rtl/theta_column_parity_if.sv
// Bus between the round controller / shared state RAM and the theta stage.
// "slave" is the theta block's view: it answers start with ready and masters
// the RAM strobes. "master" is the controller/RAM side of the same signals.
interface theta_column_parity_if #(
  parameter int W = 64
);
  logic         start;
  logic         ready;
  logic [4:0]   mem_addr;
  logic         mem_rd;
  logic [W-1:0] mem_rdata;
  logic         mem_wr;
  logic [W-1:0] mem_wdata;

  modport master (
    output start,
    output mem_rdata,
    input  ready,
    input  mem_addr,
    input  mem_rd,
    input  mem_wr,
    input  mem_wdata
  );

  modport slave (
    input  start,
    input  mem_rdata,
    output ready,
    output mem_addr,
    output mem_rd,
    output mem_wr,
    output mem_wdata
  );
endinterface

// File: rtl/theta_column_parity.sv
// Theta (column parity) stage of the encoder round.
// Phase 1 streams lanes 0..24 out of the state RAM and folds each into its
// column parity C[x]. Phase 2 forms D[x] from neighbouring columns and
// rewrites every lane as A ^ D[x] with read/write pairs, lanes in order.
// Optional build macro THETA_DBG_EN adds dbg_c (the five column parities)
// and dbg_done (one-cycle pulse after the final write).
module theta_column_parity #(
  parameter int W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  theta_column_parity_if.slave bus
`ifdef THETA_DBG_EN
  ,
  output logic [5*W-1:0]       dbg_c,
  output logic                 dbg_done
`endif
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD    = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] CALC  = 3'd3;
  localparam logic [2:0] URD   = 3'd4;
  localparam logic [2:0] UWR   = 3'd5;

  localparam logic [4:0] LAST_LANE = 5'd24;
  localparam logic [2:0] LAST_COL  = 3'd4;

  logic [2:0]   state_q, state_d;
  logic [4:0]   laneIdx_q, laneIdx_d;
  logic [2:0]   colIdx_q, colIdx_d;
  logic [2:0]   prevCol_q;
  logic [W-1:0] colPar_q [5];
  logic [W-1:0] thetaD_q [5];
  logic         ready_q;
  logic         rdStrobe;
  logic         wrStrobe;
  logic         accumulate;
  logic [2:0]   colNext;

  function automatic logic [W-1:0] rotl1(input logic [W-1:0] v);
    return {v[W-2:0], v[W-1]};
  endfunction

  assign colNext    = (colIdx_q == LAST_COL) ? 3'd0 : colIdx_q + 3'd1;
  assign rdStrobe   = (state_q == RD) || (state_q == URD);
  assign wrStrobe   = (state_q == UWR);
  // Read data lags the strobe by a cycle, so lane k-1 lands during RD k>0
  // and the last lane lands during DRAIN.
  assign accumulate = ((state_q == RD) && (laneIdx_q != 5'd0)) || (state_q == DRAIN);

  // Sequencer: lane index k and its column k mod 5 advance together.
  always_comb begin
    state_d   = state_q;
    laneIdx_d = laneIdx_q;
    colIdx_d  = colIdx_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = RD;
          laneIdx_d = 5'd0;
          colIdx_d  = 3'd0;
        end
      end
      RD: begin
        if (laneIdx_q == LAST_LANE) begin
          state_d = DRAIN;
        end else begin
          laneIdx_d = laneIdx_q + 5'd1;
          colIdx_d  = colNext;
        end
      end
      DRAIN: begin
        state_d = CALC;
      end
      CALC: begin
        state_d   = URD;
        laneIdx_d = 5'd0;
        colIdx_d  = 3'd0;
      end
      URD: begin
        state_d = UWR;
      end
      UWR: begin
        if (laneIdx_q == LAST_LANE) begin
          state_d = IDLE;
        end else begin
          state_d   = URD;
          laneIdx_d = laneIdx_q + 5'd1;
          colIdx_d  = colNext;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, lane and column registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      laneIdx_q <= '0;
      colIdx_q  <= '0;
    end else begin
      state_q   <= state_d;
      laneIdx_q <= laneIdx_d;
      colIdx_q  <= colIdx_d;
    end
  end

  // Ready is the registered decode of the upcoming state, so it is high
  // exactly while the sequencer sits in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= (state_d == IDLE);
    end
  end

  // Column parity accumulation and D[x] formation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int x = 0; x < 5; x++) begin
        colPar_q[x] <= '0;
        thetaD_q[x] <= '0;
      end
      prevCol_q <= '0;
    end else begin
      if ((state_q == IDLE) && bus.start) begin
        for (int x = 0; x < 5; x++) begin
          colPar_q[x] <= '0;
        end
      end else if (accumulate) begin
        colPar_q[prevCol_q] <= colPar_q[prevCol_q] ^ bus.mem_rdata;
      end
      if (state_q == RD) begin
        prevCol_q <= colIdx_q;
      end
      if (state_q == CALC) begin
        thetaD_q[0] <= colPar_q[4] ^ rotl1(colPar_q[1]);
        thetaD_q[1] <= colPar_q[0] ^ rotl1(colPar_q[2]);
        thetaD_q[2] <= colPar_q[1] ^ rotl1(colPar_q[3]);
        thetaD_q[3] <= colPar_q[2] ^ rotl1(colPar_q[4]);
        thetaD_q[4] <= colPar_q[3] ^ rotl1(colPar_q[0]);
      end
    end
  end

  assign bus.ready     = ready_q;
  assign bus.mem_rd    = rdStrobe;
  assign bus.mem_wr    = wrStrobe;
  assign bus.mem_addr  = (rdStrobe || wrStrobe) ? laneIdx_q : 5'd0;
  assign bus.mem_wdata = wrStrobe ? (bus.mem_rdata ^ thetaD_q[colIdx_q]) : '0;

`ifdef THETA_DBG_EN
  logic dbgDone_q;

  // Flags the cycle right after the final lane write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbgDone_q <= 1'b0;
    end else begin
      dbgDone_q <= (state_q == UWR) && (laneIdx_q == LAST_LANE);
    end
  end

  assign dbg_c    = {colPar_q[4], colPar_q[3], colPar_q[2], colPar_q[1], colPar_q[0]};
  assign dbg_done = dbgDone_q;
`endif

endmodule

// File: tb/tb_theta_column_parity.sv
// Bench for theta_column_parity: 1-cycle-latency RAM model, a lane-array
// reference of the theta step, directed vector table and corner sequences.
module tb_theta_column_parity;

  localparam int W = 64;

  typedef logic [W-1:0] lanes_t [25];

  typedef struct {
    string        name;
    int           lane;
    logic [W-1:0] val;
    int           probe;
    logic [W-1:0] exp;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst;
  lanes_t ram;
  lanes_t image;
  bit     loadNow = 1'b0;
  int     total = 0;
  int     bad = 0;

  always #5 clk = ~clk;

  theta_column_parity_if #(.W(W)) bus ();

`ifdef THETA_DBG_EN
  logic [5*W-1:0] dbgC;
  logic           dbgDone;
`endif

  theta_column_parity #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef THETA_DBG_EN
    ,
    .dbg_c    (dbgC),
    .dbg_done (dbgDone)
`endif
  );

  // Shared state RAM: write on strobe, read data one cycle after the strobe.
  always @(posedge clk) begin
    if (loadNow) ram <= image;
    else if (bus.mem_wr) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input lanes_t img);
    image = img;
    @(negedge clk);
    loadNow = 1'b1;
    @(negedge clk);
    loadNow = 1'b0;
  endtask

  // Theta on a whole state: column parities, D from neighbours, XOR back.
  task automatic thetaRef(input lanes_t a, output lanes_t r);
    logic [W-1:0] c [5];
    logic [W-1:0] d [5];
    logic [W-1:0] n;
    for (int x = 0; x < 5; x++) begin
      c[x] = '0;
      for (int y = 0; y < 5; y++) c[x] = c[x] ^ a[x + 5 * y];
    end
    for (int x = 0; x < 5; x++) begin
      n = c[(x + 1) % 5];
      d[x] = c[(x + 4) % 5] ^ ((n << 1) | (n >> (W - 1)));
    end
    for (int i = 0; i < 25; i++) r[i] = a[i] ^ d[i % 5];
  endtask

  task automatic compareRam(input string name, input lanes_t exp);
    int m = 0;
    for (int i = 0; i < 25; i++) if (ram[i] !== exp[i]) m++;
    checkOutput(name, 64'(m), 64'd0);
  endtask

  task automatic countQuiet(input int cycles, output int noisy);
    noisy = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (bus.mem_rd || bus.mem_wr || bus.ready !== 1'b1) noisy++;
    end
  endtask

  // One operation from a 1-cycle start pulse; start is re-pulsed at busy
  // cycles pA/pB to show it is ignored. Checks busy length, the exact
  // read/write lane sequence and strobe hygiene.
  task automatic runOp(input int pA, input int pB, output int busy);
    int evQ[$];
    int expQ[$];
    int viol = 0;
    int mism = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    busy = 0;
    while (bus.ready === 1'b0 && busy < 200) begin
      if (bus.mem_rd && bus.mem_wr) viol++;
      if (!bus.mem_wr && bus.mem_wdata != '0) viol++;
      if (bus.mem_rd) evQ.push_back(int'(bus.mem_addr));
      else if (bus.mem_wr) evQ.push_back(32 + int'(bus.mem_addr));
      else evQ.push_back(99);
      bus.start = (busy == pA || busy == pB);
      busy++;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    for (int k = 0; k < 25; k++) expQ.push_back(k);
    expQ.push_back(99);
    expQ.push_back(99);
    for (int k = 0; k < 25; k++) begin
      expQ.push_back(k);
      expQ.push_back(32 + k);
    end
    if (evQ.size() != expQ.size()) mism++;
    for (int i = 0; i < evQ.size() && i < expQ.size(); i++) if (evQ[i] != expQ[i]) mism++;
    checkOutput("busy cycles", 64'(busy), 64'd77);
    checkOutput("lane sequence", 64'(mism), 64'd0);
    checkOutput("strobe rules", 64'(viol), 64'd0);
  endtask

  vec_t   vecs[16];
  lanes_t img;
  lanes_t refA;
  lanes_t refB;
  int     busy;
  int     noisy;
  int     hi;
  int     curLane;
  logic [W-1:0] curVal;

  initial begin
    vecs[0]  = '{"zero lane12",   0, 64'h0, 12, 64'h0};
    vecs[1]  = '{"zero lane0",    0, 64'h0,  0, 64'h0};
    vecs[2]  = '{"one lane1",     0, 64'h1,  1, 64'h1};
    vecs[3]  = '{"one lane6",     0, 64'h1,  6, 64'h1};
    vecs[4]  = '{"one lane21",    0, 64'h1, 21, 64'h1};
    vecs[5]  = '{"one lane4",     0, 64'h1,  4, 64'h2};
    vecs[6]  = '{"one lane24",    0, 64'h1, 24, 64'h2};
    vecs[7]  = '{"one lane0",     0, 64'h1,  0, 64'h1};
    vecs[8]  = '{"one lane2",     0, 64'h1,  2, 64'h0};
    vecs[9]  = '{"one lane13",    0, 64'h1, 13, 64'h0};
    vecs[10] = '{"wrap lane0",    1, 64'h8000_0000_0000_0000,  0, 64'h1};
    vecs[11] = '{"wrap lane20",   1, 64'h8000_0000_0000_0000, 20, 64'h1};
    vecs[12] = '{"wrap lane2",    1, 64'h8000_0000_0000_0000,  2, 64'h8000_0000_0000_0000};
    vecs[13] = '{"wrap lane22",   1, 64'h8000_0000_0000_0000, 22, 64'h8000_0000_0000_0000};
    vecs[14] = '{"wrap lane1",    1, 64'h8000_0000_0000_0000,  1, 64'h8000_0000_0000_0000};
    vecs[15] = '{"wrap lane3",    1, 64'h8000_0000_0000_0000,  3, 64'h0};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.mem_rdata = '0;
    #13;
    checkOutput("reset ready", 64'(bus.ready), 64'd1);
    checkOutput("reset mem_rd", 64'(bus.mem_rd), 64'd0);
    checkOutput("reset mem_wr", 64'(bus.mem_wr), 64'd0);
    checkOutput("reset mem_addr", 64'(bus.mem_addr), 64'd0);
    checkOutput("reset mem_wdata", bus.mem_wdata, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    countQuiet(10, noisy);
    checkOutput("idle quiet", 64'(noisy), 64'd0);

    // Directed vectors: rerun only when the initial state changes.
    curLane = -1;
    curVal = '0;
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].lane != curLane || vecs[i].val !== curVal || i == 0) begin
        for (int j = 0; j < 25; j++) img[j] = '0;
        img[vecs[i].lane] = vecs[i].val;
        applyStimulus(img);
        runOp(-1, -1, busy);
        thetaRef(img, refA);
        compareRam({vecs[i].name, " full state"}, refA);
        curLane = vecs[i].lane;
        curVal = vecs[i].val;
      end
      checkOutput(vecs[i].name, ram[vecs[i].probe], vecs[i].exp);
    end

    // Random states against the lane-array reference.
    for (int t = 0; t < 4; t++) begin
      for (int j = 0; j < 25; j++) img[j] = {$urandom, $urandom};
      applyStimulus(img);
      runOp(-1, -1, busy);
      thetaRef(img, refA);
      compareRam("random state", refA);
    end

    // Start pulses while busy must not restart or extend the operation.
    for (int j = 0; j < 25; j++) img[j] = {$urandom, $urandom};
    applyStimulus(img);
    runOp(5, 60, busy);
    @(posedge clk); #1;
    checkOutput("no restart ready", 64'(bus.ready), 64'd1);
    thetaRef(img, refA);
    compareRam("busy start ignored", refA);

    // Start held high: back-to-back operations with one ready cycle between.
    for (int j = 0; j < 25; j++) img[j] = {$urandom, $urandom};
    applyStimulus(img);
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    busy = 0;
    while (bus.ready === 1'b0 && busy < 200) begin
      busy++;
      @(posedge clk); #1;
    end
    checkOutput("held op1 busy", 64'(busy), 64'd77);
    hi = 0;
    while (bus.ready === 1'b1 && hi < 10) begin
      hi++;
      @(posedge clk); #1;
    end
    checkOutput("held ready gap", 64'(hi), 64'd1);
    bus.start = 1'b0;
    busy = 0;
    while (bus.ready === 1'b0 && busy < 200) begin
      busy++;
      @(posedge clk); #1;
    end
    checkOutput("held op2 busy", 64'(busy), 64'd77);
    @(posedge clk); #1;
    checkOutput("held stop ready", 64'(bus.ready), 64'd1);
    thetaRef(img, refA);
    thetaRef(refA, refB);
    compareRam("held double theta", refB);

    // Reset in the update phase just after lane 6 is written.
    for (int j = 0; j < 25; j++) img[j] = {$urandom, $urandom};
    applyStimulus(img);
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
    end
    checkOutput("cut point wr", 64'(bus.mem_wr), 64'd1);
    checkOutput("cut point addr", 64'(bus.mem_addr), 64'd6);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checkOutput("midrst ready", 64'(bus.ready), 64'd1);
    checkOutput("midrst mem_rd", 64'(bus.mem_rd), 64'd0);
    checkOutput("midrst mem_wr", 64'(bus.mem_wr), 64'd0);
    checkOutput("midrst mem_addr", 64'(bus.mem_addr), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    countQuiet(5, noisy);
    checkOutput("midrst quiet", 64'(noisy), 64'd0);
    thetaRef(img, refA);
    for (int j = 7; j < 25; j++) refA[j] = img[j];
    compareRam("midrst partial state", refA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
